// File: rtl/spi_register_controller.sv
// -----------------------------------------------------------------------------
// spi_register_controller
//
// Command sequencer behind an SPI slave.  It gives an external SPI master
// read/write access to a register file.  Each chip-select frame starts with a
// command word: bit WIDTH-1 selects write (1) or read (0), and bits
// ADDR_BITS-1:0 give the start address.  The remaining words are data.  They
// are written to, or read from, consecutive addresses.  The address
// auto-increments and wraps modulo 2^ADDR_BITS.
//
// Ports
//   system_clk   in   system clock, all logic on the rising edge
//   rst_n        in   asynchronous reset, active low
//   cs_start     in   one-cycle pulse: chip select asserted
//   cs_stop      in   one-cycle pulse: chip select released
//   value_valid  in   one-cycle pulse: value_mosi holds a complete word
//   value_mosi   in   word received from the master
//   value_miso   out  word the slave shifts out next
//   reg_addr     out  register address
//   reg_wdata    out  register write data
//   reg_we       out  one-cycle write strobe
//   reg_re       out  one-cycle read strobe; reg_rdata is valid one cycle later
//   reg_rdata    in   register read data
//   busy         out  high while a frame is in progress (not IDLE)
//   txn_done     out  one-cycle pulse when a frame ends
//   txn_count    out  completed frames, modulo 2^WIDTH
// -----------------------------------------------------------------------------
module spi_register_controller #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 system_clk,
    input  logic                 rst_n,
    input  logic                 cs_start,
    input  logic                 cs_stop,
    input  logic                 value_valid,
    input  logic [WIDTH-1:0]     value_mosi,
    output logic [WIDTH-1:0]     value_miso,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [WIDTH-1:0]     reg_wdata,
    output logic                 reg_we,
    output logic                 reg_re,
    input  logic [WIDTH-1:0]     reg_rdata,
    output logic                 busy,
    output logic                 txn_done,
    output logic [WIDTH-1:0]     txn_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_FETCH,
        ST_RDATA
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
    logic [WIDTH-1:0]     miso_q, miso_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 we_q, we_d;
    logic                 re_q, re_d;
    logic                 done_q, done_d;
    logic                 cap_q, cap_d;

    logic                 cmd_write;
    logic [ADDR_BITS-1:0] cmd_addr;

    assign cmd_write = value_mosi[WIDTH-1];
    assign cmd_addr  = value_mosi[ADDR_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        miso_d     = miso_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        done_d     = 1'b0;
        // The register file answers one cycle after the read strobe, so
        // capture is armed in the cycle that follows reg_re.
        cap_d      = re_q;

        case (state_q)
            ST_IDLE: begin
                // Status word for the master while no frame is active.
                miso_d = count_q;
                if (cs_start) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (value_valid) begin
                    addr_d     = cmd_addr;
                    reg_addr_d = cmd_addr;
                    if (cmd_write) begin
                        miso_d  = '0;
                        state_d = ST_WDATA;
                    end else begin
                        // Prefetch the first word so it is ready for the
                        // master's first data word.
                        re_d    = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WDATA: begin
                miso_d = '0;
                if (value_valid) begin
                    we_d       = 1'b1;
                    reg_addr_d = addr_q;
                    wdata_d    = value_mosi;
                    addr_d     = addr_q + 1'b1;
                end
            end
            ST_FETCH: begin
                addr_d  = addr_q + 1'b1;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                // Fetched data lands in the first RDATA cycle. That is well
                // before the next word boundary, given the minimum SPI
                // half-period.
                if (cap_q) begin
                    miso_d = reg_rdata;
                end
                if (value_valid) begin
                    re_d       = 1'b1;
                    reg_addr_d = addr_q;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame boundaries override the per-state result.  A word that
        // arrives together with cs_stop still issues its strobe.  A cs_start
        // inside a frame means the stop was lost.  In that case the frame is
        // restarted without being counted.
        if (state_q != ST_IDLE) begin
            if (cs_start) begin
                state_d = ST_CMD;
                miso_d  = count_q;
                we_d    = 1'b0;
                re_d    = 1'b0;
            end else if (cs_stop) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                count_d = count_q + 1'b1;
                miso_d  = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            reg_addr_q <= '0;
            miso_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            done_q     <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            miso_q     <= miso_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            we_q       <= we_d;
            re_q       <= re_d;
            done_q     <= done_d;
            cap_q      <= cap_d;
        end
    end

    assign value_miso = miso_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = (state_q != ST_IDLE);
    assign txn_done   = done_q;
    assign txn_count  = count_q;

endmodule
